// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter sharing one CBus slave among masters.
// Ports: clk/resetn, ireqs/iresps (masters), oreq/oresp (slave), busy, owner.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] owner
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] owner_q;

  logic             pick_vld;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] scan;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] i
  );
    if (int'(i) >= NUM_INPUTS - 1) return '0;
    return i + 1'b1;
  endfunction

  // First valid master at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    scan     = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scan = IDX_W'((int'(rr_ptr_q) + k) % NUM_INPUTS);
      if (!pick_vld && ireqs[scan].valid) begin
        pick_vld = 1'b1;
        pick     = scan;
      end
    end
  end

  // The winner is routed in the cycle it is chosen.
  always_comb begin
    gnt_vld = (state_q == BUSY) || pick_vld;
    gnt     = (state_q == BUSY) ? owner_q : pick;
    oreq    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (gnt_vld) begin
      oreq         = ireqs[gnt];
      iresps[gnt]  = oresp;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q <= pick;
            if (oresp.last) begin
              rr_ptr_q <= nxt(pick);
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (oresp.last) begin
            state_q  <= IDLE;
            rr_ptr_q <= nxt(owner_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == BUSY);
  assign owner = owner_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: randomized + directed check of cbus_rr_arbiter
// against a priority-queue reference model.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;
  localparam int IW = 2;

  logic       clk;
  logic       resetn;
  cbus_req_t  reqs   [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [IW-1:0] owner;

  int total;
  int bad;
  int fin;

  bit m_busy;
  int m_owner;
  int order[$];

  cbus_rr_arbiter #(
    .NUM_INPUTS(N),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ireqs(reqs),
    .iresps(iresps),
    .oreq(oreq),
    .oresp(oresp),
    .busy(busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_pick();
    if (m_busy) return m_owner;
    foreach (order[k]) begin
      if (reqs[order[k]].valid) return order[k];
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    order   = {};
    for (int i = 0; i < N; i++) order.push_back(i);
  endtask

  task automatic mk_req(input int i, input int len);
    reqs[i].valid    = 1'b1;
    reqs[i].is_write = 1'($urandom % 2);
    reqs[i].addr     = $urandom;
    reqs[i].len      = 4'(len);
    reqs[i].data     = $urandom;
    reqs[i].strb     = 4'hf;
  endtask

  task automatic slv(input bit rdy, input bit lst);
    oresp.ready = rdy;
    oresp.last  = lst;
    oresp.data  = $urandom;
  endtask

  task automatic idle_bus();
    for (int i = 0; i < N; i++) reqs[i] = '0;
    oresp = '0;
  endtask

  // Check one cycle against the model, then advance it across the edge.
  task automatic step(input bit do_chk);
    int p;
    int tgt;
    cbus_req_t  er;
    cbus_resp_t ez;
    #1;
    p = m_pick();
    if (do_chk) begin
      er = (p >= 0) ? reqs[p] : '0;
      chk("oreq", 128'(oreq), 128'(er));
      for (int i = 0; i < N; i++) begin
        ez = (i == p) ? oresp : '0;
        chk($sformatf("iresp%0d", i), 128'(iresps[i]), 128'(ez));
      end
      chk("busy", 128'(busy), 128'(m_busy));
      chk("owner", 128'(owner), 128'(m_owner));
    end
    @(posedge clk);
    fin = -1;
    if (!resetn) begin
      m_reset();
    end else if (p >= 0) begin
      m_owner = p;
      if (oresp.last) begin
        m_busy = 1'b0;
        fin    = p;
        tgt    = (p + 1) % N;
        while (order[0] != tgt) order.push_back(order.pop_front());
      end else begin
        m_busy = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit c);
    resetn = 1'b0;
    idle_bus();
    step(c);
    resetn = 1'b1;
  endtask

  initial begin
    int g;
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    m_reset();
    do_reset(1'b0);

    // idle after reset
    #1;
    chk("t1_valid", 128'(oreq.valid), 128'(0));
    chk("t1_busy", 128'(busy), 128'(0));
    step(1'b1);

    // lone m1, 4-beat burst
    mk_req(1, 4);
    for (int b = 0; b < 4; b++) begin
      slv(1'b1, b == 3);
      #1;
      chk("t2_route", 128'(iresps[1].ready), 128'(1));
      step(1'b1);
    end
    reqs[1] = '0;
    slv(1'b0, 1'b0);
    step(1'b1);
    mk_req(0, 1);
    mk_req(2, 1);
    slv(1'b1, 1'b1);
    #1;
    chk("t2_ptr", 128'(iresps[2].ready), 128'(1));
    step(1'b1);
    reqs[2] = '0;
    step(1'b1);
    reqs[0] = '0;

    // all valid, single-beat rotation
    do_reset(1'b1);
    for (int i = 0; i < N; i++) mk_req(i, 1);
    for (int k = 0; k < 6; k++) begin
      slv(1'b1, 1'b1);
      #1;
      g = -1;
      for (int i = 0; i < N; i++) if (iresps[i].ready) g = i;
      chk("t3_order", 128'(g), 128'(k % N));
      step(1'b1);
      if (fin >= 0) mk_req(fin, 1);
    end
    idle_bus();

    // no preemption mid-burst
    do_reset(1'b1);
    mk_req(0, 4);
    slv(1'b1, 1'b0);
    step(1'b1);
    mk_req(1, 4);
    slv(1'b1, 1'b0);
    #1;
    chk("t4_m1_blocked", 128'(iresps[1].ready), 128'(0));
    step(1'b1);
    slv(1'b0, 1'b0);
    step(1'b1);
    slv(1'b1, 1'b0);
    step(1'b1);
    slv(1'b1, 1'b1);
    step(1'b1);
    reqs[0] = '0;
    slv(1'b1, 1'b0);
    #1;
    chk("t4_m1_gnt", 128'(iresps[1].ready), 128'(1));
    step(1'b1);
    slv(1'b1, 1'b1);
    step(1'b1);
    reqs[1] = '0;

    // single-beat in first idle cycle, pointer wraps
    do_reset(1'b1);
    mk_req(2, 1);
    slv(1'b1, 1'b1);
    step(1'b1);
    reqs[2] = '0;
    #1;
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_owner", 128'(owner), 128'(2));
    for (int i = 0; i < N; i++) mk_req(i, 1);
    slv(1'b1, 1'b1);
    #1;
    chk("t5_wrap", 128'(iresps[0].ready), 128'(1));
    step(1'b1);
    idle_bus();

    // reset mid-burst
    do_reset(1'b1);
    mk_req(0, 1);
    slv(1'b1, 1'b1);
    step(1'b1);
    reqs[0] = '0;
    mk_req(1, 4);
    slv(1'b1, 1'b0);
    step(1'b1);
    slv(1'b1, 1'b0);
    resetn = 1'b0;
    step(1'b1);
    resetn = 1'b1;
    idle_bus();
    #1;
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_oreq", 128'(oreq), 128'(0));
    step(1'b1);
    for (int i = 0; i < N; i++) mk_req(i, 1);
    slv(1'b1, 1'b1);
    #1;
    chk("t6_ptr", 128'(iresps[0].ready), 128'(1));
    step(1'b1);
    idle_bus();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom % 100) != 0;
      for (int i = 0; i < N; i++) begin
        if (!reqs[i].valid && ($urandom % 3 == 0)) begin
          mk_req(i, $urandom_range(1, 8));
        end
      end
      g = int'($urandom % 4);
      slv(g != 0, (g != 0) && ($urandom % 3 == 0));
      step(1'b1);
      if (fin >= 0) reqs[fin] = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
